rs232_avm_slave: RTL and testbench
==================================

RS232_AVM_SLAVE -- requirements
Module: rs232_avm_slave

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, entries per RX and TX byte FIFO (power of two, >=2).
REQ-003 SHALL have port avm_clk  input  1  the single clock.
REQ-004 SHALL have port avm_rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports avm_address input 5, avm_read input 1, avm_write input 1, avm_writedata input 32: Avalon-MM slave request.
REQ-006 SHALL have ports avm_readdata output 32, avm_waitrequest output 1: Avalon-MM slave response.
REQ-007 SHALL have ports uart_rxd input 1 (serial in, idle high) and uart_txd output 1 (serial out, idle high).

Function
REQ-008 SHALL decode addresses RX=0x00, TX=0x04, STATUS=0x08; all other addresses read 0, writes ignored.
REQ-009 SHALL run a bus FSM IDLE->ACK->IDLE: IDLE with read or write -> waitrequest=1, latch request, go ACK; ACK -> waitrequest=0, response valid, go IDLE.
REQ-010 SHALL hold avm_waitrequest=1 in IDLE whenever read or write is asserted, 0 otherwise; read and write together is treated as read.
REQ-011 SHALL, in ACK of an RX read, drive readdata={24'b0, RX head byte} and pop RX at cycle end; RX empty -> readdata=0, no pop.
REQ-012 SHALL, in ACK of a STATUS read, drive bit7=RX not empty, bit6=TX not full, bit8=RX overrun sticky, bit9=framing-error sticky, other bits 0, and clear both stickies at cycle end.
REQ-013 SHALL, in ACK of a TX write, push writedata[7:0] into TX FIFO; TX full -> byte dropped, no other effect.
REQ-014 SHALL double-flop uart_rxd before use.
REQ-015 SHALL run RX FSM IDLE/START/DATA/STOP: falling edge -> START; at CLKS_PER_BIT/2 still low -> DATA else IDLE; 8 bits LSB first sampled every CLKS_PER_BIT; STOP sample one bit later.
REQ-016 SHALL push the received byte when stop bit=1; stop bit=0 -> discard byte, set framing sticky.
REQ-017 SHALL, when the RX FIFO is full at push, drop the new byte and set overrun sticky; a simultaneous bus pop frees space first, so the push succeeds.
REQ-018 SHALL run TX FSM IDLE/START/DATA/STOP: IDLE and TX not empty -> pop, drive start 0, 8 data bits LSB first, stop 1, each CLKS_PER_BIT cycles, then IDLE.
REQ-019 SHALL allow simultaneous bus push and TX pop on the same cycle, including when the TX FIFO is full.
REQ-020 SHALL wrap FIFO pointers modulo FIFO_DEPTH and use an extra pointer bit to tell full from empty.

Reset
REQ-021 SHALL on avm_rst set: bus FSM IDLE, avm_waitrequest=0, avm_readdata=0, uart_txd=1, RX/TX FSMs IDLE, FIFOs empty, stickies 0, bit counters 0.
REQ-022 SHALL abort any in-flight frame or bus access on reset; the aborted access is not acknowledged.

Configuration
REQ-023 SHALL, with RS232_FIFO_EN defined, use FIFO_DEPTH-entry RX and TX FIFOs.
REQ-024 SHALL, with RS232_FIFO_EN undefined, replace each FIFO with a one-byte holding register (full=valid) and ignore FIFO_DEPTH; all other behaviour is unchanged.

Structure
REQ-025 SHALL take address constants, status bit positions (RRDY=7, TRDY=6, OVR=8, FE=9) and bus/RX/TX state enums from package rs232_pkg.
REQ-026 SHALL instantiate sub-module rs232_fifo (push/pop/full/empty/head, 8-bit data) twice, for RX and TX.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4, RS232_FIFO_EN defined unless noted)
REQ-027 SHALL check: serial 0xA5 on uart_rxd -> STATUS read bit7=1; RX read returns 0x000000A5; next STATUS bit7=0.
REQ-028 SHALL check: TX write 0x3C -> uart_txd low 4 cycles, then bits 0,0,1,1,1,1,0,0 of 4 cycles each, then high; STATUS bit6 stays 1.
REQ-029 SHALL check: 5 serial bytes 0x01..0x05 with no reads -> reads return 0x01..0x04, bit8=1 on first STATUS read, 0 on second.
REQ-030 SHALL check: frame 0x77 with stop bit 0 -> bit7=0, bit9=1; a following good 0x11 is received.
REQ-031 SHALL check: each access shows waitrequest=1 for exactly 1 cycle, then 0; back-to-back STATUS reads every 2 cycles all complete.
REQ-032 SHALL check: RS232_FIFO_EN undefined; two TX writes 0xAA, 0xBB during the first frame -> 0xAA sent, 0xBB sent only if the holding register had emptied, else bit6=0 and 0xBB dropped.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared constants, state encodings and status-word helper for the RS-232 Avalon-MM slave.
package rs232_pkg;

    localparam logic [4:0] ADDR_RX     = 5'h00;
    localparam logic [4:0] ADDR_TX     = 5'h04;
    localparam logic [4:0] ADDR_STATUS = 5'h08;

    localparam int ST_TRDY = 6;
    localparam int ST_RRDY = 7;
    localparam int ST_OVR  = 8;
    localparam int ST_FE   = 9;

    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } bus_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    function automatic logic [31:0] status_word(input logic rrdy, input logic trdy,
                                                input logic ovr, input logic fe);
        logic [31:0] w;
        w          = '0;
        w[ST_RRDY] = rrdy;
        w[ST_TRDY] = trdy;
        w[ST_OVR]  = ovr;
        w[ST_FE]   = fe;
        return w;
    endfunction

endpackage

// File: rtl/rs232_fifo.sv
// 8-bit byte FIFO; with RS232_FIFO_EN undefined it collapses to a one-byte holding register.
// A pop on the same cycle as a push always frees room first, so push-while-full succeeds.
module rs232_fifo
    import rs232_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output logic [7:0] o_head,
    output logic       o_drop
);

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_drop    = i_push & ~w_do_push;

`ifdef RS232_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    // Extra MSB distinguishes full (MSBs differ) from empty (pointers equal).
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
`else
    logic        r_valid;
    logic [7:0]  r_data;
    logic [31:0] w_depth_unused;

    assign w_depth_unused = DEPTH;
    assign o_empty = ~r_valid;
    assign o_full  = r_valid;
    assign o_head  = r_data;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_valid <= 1'b0;
        end else if (w_do_push) begin
            r_valid <= 1'b1;
        end else if (w_do_pop) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_data <= i_data;
    end
`endif

endmodule

// File: rtl/rs232_avm_slave.sv
// RS-232 UART with Avalon-MM slave: RX/TX byte FIFOs (RS232_FIFO_EN selects deep FIFOs
// over one-byte holding registers), a two-state bus handshake and sticky error flags.
module rs232_avm_slave
    import rs232_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avm_address,
    input  logic        avm_read,
    input  logic        avm_write,
    input  logic [31:0] avm_writedata,
    output logic [31:0] avm_readdata,
    output logic        avm_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int            CW        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    bus_state_t  r_bus_state;
    logic        r_req_rd;
    logic [4:0]  r_req_addr;
    logic [7:0]  r_req_data;
    logic        r_ovr;
    logic        r_fe;

    rx_state_t   r_rx_state;
    logic        r_rxd_meta;
    logic        r_rxd_sync;
    logic        r_rxd_prev;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        r_rx_push;
    logic        r_rx_fe;

    tx_state_t   r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_txd;

    logic        w_ack;
    logic        w_rx_pop;
    logic        w_st_clr;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_rx_empty;
    logic        w_rx_full_unused;
    logic [7:0]  w_rx_head;
    logic        w_rx_drop;
    logic        w_tx_empty;
    logic        w_tx_full;
    logic [7:0]  w_tx_head;
    logic        w_tx_drop_unused;
    logic        w_wdata_unused;
    logic [31:0] w_rd_mux;

    assign w_wdata_unused = ^avm_writedata[31:8];

    rs232_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (avm_clk),
        .i_srst  (avm_rst),
        .i_push  (r_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full_unused),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head),
        .o_drop  (w_rx_drop)
    );

    rs232_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (avm_clk),
        .i_srst  (avm_rst),
        .i_push  (w_tx_push),
        .i_data  (r_req_data),
        .i_pop   (w_tx_pop),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (w_tx_head),
        .o_drop  (w_tx_drop_unused)
    );

    // Waitrequest must rise in the same cycle the master asserts a request.
    assign avm_waitrequest = (r_bus_state == BUS_IDLE) && (avm_read || avm_write);
    assign w_ack     = (r_bus_state == BUS_ACK);
    assign w_rx_pop  = w_ack &  r_req_rd & (r_req_addr == ADDR_RX);
    assign w_st_clr  = w_ack &  r_req_rd & (r_req_addr == ADDR_STATUS);
    assign w_tx_push = w_ack & ~r_req_rd & (r_req_addr == ADDR_TX);
    assign w_tx_pop  = (r_tx_state == TX_IDLE) & ~w_tx_empty;

    always_comb begin
        w_rd_mux = '0;
        case (r_req_addr)
            ADDR_RX:     w_rd_mux = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
            ADDR_STATUS: w_rd_mux = status_word(~w_rx_empty, ~w_tx_full, r_ovr, r_fe);
            default:     w_rd_mux = '0;
        endcase
    end

    assign avm_readdata = (w_ack && r_req_rd) ? w_rd_mux : 32'h0;
    assign uart_txd     = r_txd;

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            r_bus_state <= BUS_IDLE;
            r_req_rd    <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
        end else begin
            case (r_bus_state)
                BUS_IDLE: begin
                    if (avm_read || avm_write) begin
                        r_req_rd    <= avm_read;
                        r_req_addr  <= avm_address;
                        r_req_data  <= avm_writedata[7:0];
                        r_bus_state <= BUS_ACK;
                    end
                end
                default: r_bus_state <= BUS_IDLE;
            endcase
        end
    end

    // New error events win over a same-cycle STATUS clear so none are lost.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            r_ovr <= 1'b0;
            r_fe  <= 1'b0;
        end else begin
            if (w_st_clr) begin
                r_ovr <= 1'b0;
                r_fe  <= 1'b0;
            end
            if (w_rx_drop) r_ovr <= 1'b1;
            if (r_rx_fe)   r_fe  <= 1'b1;
        end
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_push  <= 1'b0;
            r_rx_fe    <= 1'b0;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
            r_rx_push  <= 1'b0;
            r_rx_fe    <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rxd_prev && !r_rxd_sync) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rxd_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (r_rxd_sync) r_rx_push <= 1'b1;
                        else            r_rx_fe   <= 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_txd <= 1'b1;
                    if (!w_tx_empty) begin
                        r_tx_shift <= w_tx_head;
                        r_txd      <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_txd      <= r_tx_shift[1];
                            r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_avm_slave.sv
// Directed bench for rs232_avm_slave (CLKS_PER_BIT=4, FIFO_DEPTH=4); expectations follow RS232_FIFO_EN.
module tb_rs232_avm_slave;
    import rs232_pkg::*;

    localparam int CPB = 4;

    logic        avm_clk = 1'b0;
    logic        avm_rst;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        uart_rxd;
    logic        uart_txd;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 avm_clk = ~avm_clk;
    always @(posedge avm_clk) cyc <= cyc + 1;

    rs232_avm_slave #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .uart_rxd        (uart_rxd),
        .uart_txd        (uart_txd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge avm_clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 so accesses can run back to back.
    task automatic bus_xfer(input logic rd, input logic [4:0] addr, input logic [31:0] wd,
                            output logic [31:0] rdata);
        int waits;
        waits         = 0;
        avm_address   = addr;
        avm_writedata = wd;
        avm_read      = rd;
        avm_write     = ~rd;
        @(negedge avm_clk);
        while (avm_waitrequest && waits < 8) begin
            waits++;
            @(negedge avm_clk);
        end
        check($sformatf("waitreq_%s_%02h", rd ? "rd" : "wr", addr), waits, 1);
        rdata = avm_readdata;
        @(posedge avm_clk);
        #1;
        avm_read  = 1'b0;
        avm_write = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_xfer(1'b1, addr, 32'h0, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        bus_xfer(1'b0, addr, wd, d);
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            wait_cyc(CPB);
        end
        uart_rxd = stop_bit;
        wait_cyc(CPB);
        uart_rxd = 1'b1;
        wait_cyc(3 * CPB);
    endtask

    // Entered on a negedge; finds the start bit, then checks every bit cell cycle by cycle.
    task automatic mon_frame(input logic [7:0] b);
        int         w;
        logic [3:0] s;
        logic       e;
        w = 0;
        while (uart_txd === 1'b1 && w < 200) begin
            @(negedge avm_clk);
            w++;
        end
        check($sformatf("tx_%02h_start_seen", b), {31'b0, uart_txd}, 32'h0);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 4; c++) begin
                s[c] = uart_txd;
                @(negedge avm_clk);
            end
            e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
            check($sformatf("tx_%02h_cell%0d", b, j), {28'b0, s}, {28'b0, {4{e}}});
        end
    endtask

    logic [7:0]  exp_rd [5];
    logic [31:0] exp_st_busy;
    int          c0;
    logic        low_seen;

    initial begin
`ifdef RS232_FIFO_EN
        exp_rd      = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        exp_st_busy = 32'h0000_0040;
`else
        exp_rd      = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_st_busy = 32'h0000_0000;
`endif
        avm_rst       = 1'b1;
        avm_address   = '0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = '0;
        uart_rxd      = 1'b1;
        repeat (3) @(posedge avm_clk);
        @(negedge avm_clk);
        check("rst_waitreq", {31'b0, avm_waitrequest}, 32'h0);
        check("rst_readdata", avm_readdata, 32'h0);
        check("rst_txd", {31'b0, uart_txd}, 32'h1);
        @(posedge avm_clk);
        #1;
        avm_rst = 1'b0;
        wait_cyc(2);
        rd_check("status_after_rst", ADDR_STATUS, 32'h0000_0040);

        // Single good byte, plus unmapped address handling.
        uart_send(8'hA5, 1'b1);
        rd_check("a5_status", ADDR_STATUS, 32'h0000_00C0);
        rd_check("unmapped_0c", 5'h0C, 32'h0);
        wr(5'h10, 32'h0000_00FF);
        rd_check("a5_rx", ADDR_RX, 32'h0000_00A5);
        rd_check("a5_status_after", ADDR_STATUS, 32'h0000_0040);
        rd_check("rx_empty_read", ADDR_RX, 32'h0);

        // Framing error, then recovery on a good frame.
        uart_send(8'h77, 1'b0);
        rd_check("fe_status", ADDR_STATUS, 32'h0000_0240);
        rd_check("fe_cleared", ADDR_STATUS, 32'h0000_0040);
        uart_send(8'h11, 1'b1);
        rd_check("after_fe_rx", ADDR_RX, 32'h0000_0011);

        // Single TX byte waveform.
        fork
            wr(ADDR_TX, 32'hFFFF_FF3C);
            begin
                @(negedge avm_clk);
                mon_frame(8'h3C);
            end
        join
        check("tx_idle_after_3c", {31'b0, uart_txd}, 32'h1);
        wait_cyc(1);
        rd_check("tx_status_3c", ADDR_STATUS, 32'h0000_0040);

        // Overrun: five bytes with no reads.
        for (int i = 1; i <= 5; i++) uart_send(8'(i), 1'b1);
        rd_check("ovr_status1", ADDR_STATUS, 32'h0000_01C0);
        rd_check("ovr_status2", ADDR_STATUS, 32'h0000_00C0);
        for (int i = 0; i < 5; i++)
            rd_check($sformatf("ovr_rx%0d", i), ADDR_RX, {24'h0, exp_rd[i]});

        // Back-to-back STATUS reads complete every two cycles.
        c0 = cyc;
        for (int i = 0; i < 4; i++) rd_check($sformatf("b2b_status%0d", i), ADDR_STATUS, 32'h0000_0040);
        check("b2b_cycles", cyc - c0, 8);

        // Two writes during the first frame.
        fork
            begin
                wr(ADDR_TX, 32'h0000_00AA);
                wr(ADDR_TX, 32'h0000_00BB);
                rd_check("tx_status_busy", ADDR_STATUS, exp_st_busy);
            end
            begin
                @(negedge avm_clk);
                mon_frame(8'hAA);
                mon_frame(8'hBB);
            end
        join
        wait_cyc(1);

        // Reset during the ACK cycle of a TX write must drop the access.
        avm_address   = ADDR_TX;
        avm_writedata = 32'h0000_0055;
        avm_write     = 1'b1;
        @(negedge avm_clk);
        check("abort_waitreq", {31'b0, avm_waitrequest}, 32'h1);
        @(posedge avm_clk);
        #1;
        avm_rst = 1'b1;
        @(posedge avm_clk);
        #1;
        avm_rst   = 1'b0;
        avm_write = 1'b0;
        low_seen  = 1'b0;
        repeat (60) begin
            @(negedge avm_clk);
            if (uart_txd !== 1'b1) low_seen = 1'b1;
        end
        check("abort_no_tx", {31'b0, low_seen}, 32'h0);
        wait_cyc(1);
        rd_check("abort_status", ADDR_STATUS, 32'h0000_0040);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
